wb_source_select_reg: RTL and testbench
=======================================

Name: wb_source_select_reg

Overview:
- Parametrised, registered successor to the register-file write-back data-source multiplexer in the multicycle MIPS datapath.
- Selects one of N_SRC datapath results, or a fixed constant such as the exception vector value, into a one-deep output register.
- Upstream (control unit) and downstream (register-file write port) use valid/ready handshakes.
- Adds illegal-select detection, a sticky error flag, flush, and a transfer counter.

Parameters:
- WIDTH, 32, data width of every source and of the output.
- N_SRC, 10, number of datapath sources; select code N_SRC selects CONST_VAL.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N_SRC+1.
- CONST_VAL, 227, constant returned for select code N_SRC.
- CNT_W, 16, transfer counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- src_data  in  N_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  source select; sampled with in_valid.
- in_valid  in  1  upstream has a select to capture.
- in_ready  out  1  block can capture this cycle.
- flush  in  1  discard the held result.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  select code that produced out_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream consumes out_data.
- sel_err  out  1  sticky: an illegal select was captured.
- xfer_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (reset==0 at a rising edge): out_data=0, out_sel=0, out_valid=0, sel_err=0, xfer_count=0, state=EMPTY. Reset has priority over every other input.
- States:
  - EMPTY: out_valid=0 and in_ready=1.
  - FULL: out_valid=1 and in_ready=out_ready, so the register is refilled in the same cycle it drains.
- Capture occurs when in_valid && in_ready (and flush==0):
  - sel < N_SRC: out_data <= src_data slice sel.
  - sel == N_SRC: out_data <= CONST_VAL truncated or zero-extended to WIDTH.
  - sel > N_SRC: out_data <= 0 and sel_err <= 1. This is still a normal capture; out_valid rises.
  - out_sel <= sel. Next state is FULL.
- Latency: exactly 1 cycle from capture to out_valid. No combinational path from src_data or sel to out_data.
- Drain: the handshake completes when out_valid && out_ready. xfer_count increments by 1 and wraps modulo 2**CNT_W.
- Drain without a simultaneous capture: FULL -> EMPTY. out_data holds its last value.
- Simultaneous drain and capture: stay FULL, load the new data, increment the counter once.
- flush==1, highest priority after reset:
  - Next state is EMPTY. No capture, no counter increment, even if out_ready was asserted.
  - sel_err is not cleared; only reset clears it.
- Data stability: out_data and out_sel must not change while out_valid && !out_ready.
- Illegal select values never leave out_data undriven or latched; the output is always fully defined.

Decomposition:
- Shared package (datapath_pkg): select-code localparams (SRC_ALUOUT=0, SRC_SLS=1, SRC_LO=2, SRC_HI=3, SRC_SHIFT=4, SRC_LT=5, SRC_SEXT=6, SRC_SHL16=7, SRC_REGA=8, SRC_REGB=9, SRC_CONST=10), the default WIDTH, and CONST_VAL.
- One sub-module: wb_source_mux, a purely combinational indexed select with an illegal flag, reusable by other mux generalisations.
- The handshake register and FSM live in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0, sel_err=0, xfer_count=0.
- Basic capture: src 3=0xDEADBEEF, sel=3, in_valid pulse, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=3; following cycle xfer_count=1 and state EMPTY.
- Constant and illegal selects: sel=10 -> out_data=227 (0x000000E3); then sel=12 -> out_data=0 and sel_err=1, which stays 1 through later legal transfers until reset.
- Backpressure and streaming:
  - FULL with out_ready=0 and in_valid=1 for 3 cycles -> in_ready=0, out_data stable, count unchanged.
  - Then out_ready=1 with in_valid=1 on sels 0,1,2 back-to-back -> one output per cycle, xfer_count +3.
- Flush: FULL, flush=1 together with out_ready=1 and in_valid=1 -> next cycle out_valid=0, xfer_count unchanged, no capture.
- Counter wrap: CNT_W=4, perform 17 transfers -> xfer_count=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: write-back select codes, default widths and the
// constant returned on the dedicated constant select code.
package datapath_pkg;

  localparam int DP_WIDTH     = 32;
  localparam int DP_CONST_VAL = 227;

  // Write-back source select codes of the multicycle MIPS datapath
  localparam int SRC_ALUOUT = 0;
  localparam int SRC_SLS    = 1;
  localparam int SRC_LO     = 2;
  localparam int SRC_HI     = 3;
  localparam int SRC_SHIFT  = 4;
  localparam int SRC_LT     = 5;
  localparam int SRC_SEXT   = 6;
  localparam int SRC_SHL16  = 7;
  localparam int SRC_REGA   = 8;
  localparam int SRC_REGB   = 9;
  localparam int SRC_CONST  = 10;

  localparam int DP_N_SRC   = SRC_CONST;
  localparam int DP_SEL_W   = 4;
  localparam int DP_CNT_W   = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_source_mux.sv
// Combinational indexed select over N_SRC flattened sources plus one constant
// code; any code above the constant code yields zero and raises o_illegal.
module wb_source_mux #(
  parameter int WIDTH     = 32,
  parameter int N_SRC     = 10,
  parameter int SEL_W     = 4,
  parameter int CONST_VAL = 227
) (
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_illegal
);

  localparam logic [SEL_W-1:0] LP_CONST_SEL = SEL_W'(N_SRC);
  localparam logic [WIDTH-1:0] LP_CONST     = WIDTH'(CONST_VAL);

  // Zero default keeps the output defined for every select value
  always_comb begin
    o_data    = '0;
    o_illegal = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        o_data = src_data[i*WIDTH +: WIDTH];
      end
    end
    if (sel == LP_CONST_SEL) begin
      o_data = LP_CONST;
    end
    if (sel > LP_CONST_SEL) begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/wb_source_select_reg.sv
// Registered write-back source select: one-deep output register with
// valid/ready on both sides, flush, sticky illegal-select flag and transfer count.
module wb_source_select_reg
  import datapath_pkg::*;
#(
  parameter int WIDTH     = DP_WIDTH,
  parameter int N_SRC     = DP_N_SRC,
  parameter int SEL_W     = DP_SEL_W,
  parameter int CONST_VAL = DP_CONST_VAL,
  parameter int CNT_W     = DP_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err,
  output logic [CNT_W-1:0]       xfer_count
);

  wb_state_t         r_state;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic              r_sel_err;
  logic [CNT_W-1:0]  r_xfer_count;

  logic [WIDTH-1:0]  w_mux_data;
  logic              w_mux_illegal;
  logic              w_full;
  logic              w_in_ready;
  logic              w_drain;
  logic              w_capture;

  wb_source_mux #(
    .WIDTH     (WIDTH),
    .N_SRC     (N_SRC),
    .SEL_W     (SEL_W),
    .CONST_VAL (CONST_VAL)
  ) u_mux (
    .src_data  (src_data),
    .sel       (sel),
    .o_data    (w_mux_data),
    .o_illegal (w_mux_illegal)
  );

  // A full register accepts new data only in the cycle it is being drained
  assign w_full     = (r_state == ST_FULL);
  assign w_in_ready = !w_full || out_ready;
  assign w_drain    = w_full && out_ready;
  assign w_capture  = in_valid && w_in_ready;

  // Flush wins over drain and capture; sel_err survives everything but reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_EMPTY;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_sel_err    <= 1'b0;
      r_xfer_count <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      if (w_drain) begin
        r_xfer_count <= r_xfer_count + CNT_W'(1);
      end
      if (w_capture) begin
        r_out_data <= w_mux_data;
        r_out_sel  <= sel;
        r_state    <= ST_FULL;
        if (w_mux_illegal) begin
          r_sel_err <= 1'b1;
        end
      end else if (w_drain) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_full;
  assign out_data   = r_out_data;
  assign out_sel    = r_out_sel;
  assign sel_err    = r_sel_err;
  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_wb_source_select_reg.sv
// Bench for wb_source_select_reg: directed plan steps then random traffic, all
// checked against a transaction-level model; a CNT_W=4 twin covers counter wrap.
module tb_wb_source_select_reg;
  import datapath_pkg::*;

  localparam int W  = 32;
  localparam int N  = 10;
  localparam int SW = 4;
  localparam int CV = 227;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N*W-1:0]  srcData;
  logic [SW-1:0]   sel;
  logic            inValid;
  logic            flush;
  logic            outReady;

  logic            inReady, outValid, selErr;
  logic [W-1:0]    outData;
  logic [SW-1:0]   outSel;
  logic [15:0]     xferCount;

  logic            inReady4, outValid4, selErr4;
  logic [W-1:0]    outData4;
  logic [SW-1:0]   outSel4;
  logic [3:0]      xferCount4;

  wb_source_select_reg #(.WIDTH(W), .N_SRC(N), .SEL_W(SW), .CONST_VAL(CV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .src_data(srcData), .sel(sel), .in_valid(inValid),
    .in_ready(inReady), .flush(flush), .out_data(outData), .out_sel(outSel),
    .out_valid(outValid), .out_ready(outReady), .sel_err(selErr), .xfer_count(xferCount)
  );

  wb_source_select_reg #(.WIDTH(W), .N_SRC(N), .SEL_W(SW), .CONST_VAL(CV), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .src_data(srcData), .sel(sel), .in_valid(inValid),
    .in_ready(inReady4), .flush(flush), .out_data(outData4), .out_sel(outSel4),
    .out_valid(outValid4), .out_ready(outReady), .sel_err(selErr4), .xfer_count(xferCount4)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model of the holding register
  bit         mValid;
  bit         mErr;
  logic [W-1:0]  mData;
  logic [SW-1:0] mSel;
  int         mCount;

  logic [W-1:0] savedData;
  int           savedCount;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", outValid, mValid);
    checkOutput("in_ready", inReady, (!mValid) || outReady);
    checkOutput("out_data", outData, mData);
    checkOutput("out_sel", outSel, mSel);
    checkOutput("sel_err", selErr, mErr);
    checkOutput("xfer_count", xferCount, mCount % 65536);
    checkOutput("xfer_count4", xferCount4, mCount % 16);
    checkOutput("out_data4", outData4, mData);
  endtask

  function automatic logic [W-1:0] srcWord(input int idx);
    return srcData[idx*W +: W];
  endfunction

  // One clock: predict from pre-edge inputs, then compare #1 after the edge
  task automatic applyStimulus();
    bit nValid = mValid, nErr = mErr;
    logic [W-1:0] nData = mData;
    logic [SW-1:0] nSel = mSel;
    int nCount = mCount;
    bit drain, cap;
    int s;
    if (!reset) begin
      nValid = 0; nErr = 0; nData = '0; nSel = '0; nCount = 0;
    end else if (flush) begin
      nValid = 0;
    end else begin
      drain = mValid && outReady;
      cap   = inValid && (!mValid || outReady);
      if (drain) nCount = mCount + 1;
      if (cap) begin
        s = int'(sel);
        if (s < N)       nData = srcWord(s);
        else if (s == N) nData = W'(CV);
        else begin
          nData = '0;
          nErr  = 1;
        end
        nSel   = sel;
        nValid = 1;
      end else if (drain) begin
        nValid = 0;
      end
    end
    @(posedge clk);
    #1;
    mValid = nValid; mErr = nErr; mData = nData; mSel = nSel; mCount = nCount;
    checkAll();
  endtask

  initial begin
    bit done;
    srcData = '0;
    for (int i = 0; i < N; i++) srcData[i*W +: W] = $urandom;
    reset = 1'b0; inValid = 1'b1; flush = 1'b0; outReady = 1'b0; sel = 4'd3;
    mValid = 0; mErr = 0; mData = '0; mSel = '0; mCount = 0;

    $display("[TB] reset held with in_valid high");
    applyStimulus();
    applyStimulus();
    checkOutput("reset_out_valid", outValid, 1'b0);
    checkOutput("reset_in_ready", inReady, 1'b1);
    checkOutput("reset_count", xferCount, 16'd0);

    $display("[TB] basic capture");
    reset = 1'b1;
    srcData[3*W +: W] = 32'hDEADBEEF;
    sel = 4'd3; inValid = 1'b1; outReady = 1'b1;
    applyStimulus();
    checkOutput("basic_data", outData, 32'hDEADBEEF);
    checkOutput("basic_sel", outSel, 4'd3);
    inValid = 1'b0;
    applyStimulus();
    checkOutput("basic_count", xferCount, 16'd1);
    checkOutput("basic_empty", outValid, 1'b0);

    $display("[TB] constant and illegal selects");
    sel = 4'd10; inValid = 1'b1;
    applyStimulus();
    checkOutput("const_data", outData, 32'h000000E3);
    inValid = 1'b0;
    applyStimulus();
    sel = 4'd12; inValid = 1'b1;
    applyStimulus();
    checkOutput("illegal_data", outData, 32'h0);
    checkOutput("illegal_err", selErr, 1'b1);
    checkOutput("illegal_valid", outValid, 1'b1);
    sel = 4'd5;
    applyStimulus();
    inValid = 1'b0;
    applyStimulus();
    checkOutput("err_sticky", selErr, 1'b1);

    $display("[TB] backpressure");
    sel = 4'd7; inValid = 1'b1; outReady = 1'b0;
    applyStimulus();
    savedData = srcData[7*W +: W];
    savedCount = int'(xferCount);
    sel = 4'd8;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("bp_in_ready", inReady, 1'b0);
      checkOutput("bp_data_stable", outData, savedData);
      checkOutput("bp_count", xferCount, 16'(savedCount));
    end

    $display("[TB] streaming");
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 4'(i);
      applyStimulus();
    end
    checkOutput("stream_count", xferCount, 16'(savedCount + 3));
    checkOutput("stream_data", outData, srcData[2*W +: W]);

    $display("[TB] flush");
    savedCount = int'(xferCount);
    flush = 1'b1; sel = 4'd4;
    applyStimulus();
    checkOutput("flush_valid", outValid, 1'b0);
    checkOutput("flush_count", xferCount, 16'(savedCount));
    checkOutput("flush_err_kept", selErr, 1'b1);
    flush = 1'b0; inValid = 1'b0;
    applyStimulus();

    $display("[TB] counter wrap");
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1; inValid = 1'b1; outReady = 1'b1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      sel = 4'($urandom_range(0, N - 1));
      applyStimulus();
      if (mCount == 17) done = 1;
    end
    checkOutput("wrap_reached", done, 1'b1);
    checkOutput("wrap_count4", xferCount4, 4'd1);
    checkOutput("wrap_count16", xferCount, 16'd17);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom % 64) != 0;
      flush    = ($urandom % 16) == 0;
      inValid  = $urandom % 2;
      outReady = ($urandom % 4) != 0;
      sel      = 4'($urandom % 16);
      if ($urandom % 4 == 0) begin
        for (int k = 0; k < N; k++) srcData[k*W +: W] = $urandom;
      end
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
